// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier host block.
// Holds the operand and product widths, the WAIT counter width and the
// 2-bit FSM state encoding used by mult_host.
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mult_host_if.sv
// Bus bundle between the host, mult_host and the multiplier.
//   req_valid/req_ready/a_in/b_in          : host request channel
//   rsp_valid/rsp_ready/rsp_product/rsp_timeout : host response channel
//   mul_start/mul_a/mul_b/mul_done/mul_product  : multiplier side
// slave  : view of mult_host
// master : view of the environment (host plus multiplier)
interface mult_host_if;
  import mult_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   a_in;
  logic [OP_W-1:0]   b_in;
  logic              mul_start;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic              mul_done;
  logic [PROD_W-1:0] mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PROD_W-1:0] rsp_product;
  logic              rsp_timeout;

  modport slave (
    input  req_valid, a_in, b_in, mul_done, mul_product, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_product, rsp_timeout
  );

  modport master (
    output req_valid, a_in, b_in, mul_done, mul_product, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_product, rsp_timeout
  );

endinterface

// File: rtl/mult_timeout_ctr.sv
// WAIT-state cycle counter.
//   clk, rst : clock, async active-low reset
//   clear    : force the count to zero (takes priority over enable)
//   enable   : advance the count by one
//   tc       : count equals TC_VALUE (last allowed WAIT cycle)
module mult_timeout_ctr
  import mult_pkg::*;
#(
  parameter logic [CNT_W-1:0] TC_VALUE = 8'd14
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VALUE);

endmodule

// File: rtl/mult_host.sv
// Host-side sequencer for a 4x4 unsigned multiplier.
// Accepts an operand pair, pulses mul_start, waits for mul_done with a
// bounded timeout, and returns either the product or an abort flag.
//   clk, rst : clock, async active-low reset
//   bus      : request / response / multiplier signals (slave view)
//   busy     : high in every state except IDLE
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | ready for a request, operands latched on accept
// S_LAUNCH | one-cycle mul_start pulse, counter cleared
// S_WAIT   | waiting for mul_done or timeout
// S_RESP   | response held until rsp_ready
module mult_host
  import mult_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  mult_host_if.slave  bus,
  output logic        busy
);

  // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle (count starts at 0).
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_nxt;
  logic   tc;
  logic   ctr_clear;
  logic   ctr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (bus.mul_done || tc) state_nxt = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mul_a       <= '0;
      bus.mul_b       <= '0;
      bus.rsp_product <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req_valid) begin
        bus.mul_a <= bus.a_in;
        bus.mul_b <= bus.b_in;
      end
      if (state == S_WAIT) begin
        // done has priority over a coincident timeout
        if (bus.mul_done) begin
          bus.rsp_product <= bus.mul_product;
          bus.rsp_timeout <= 1'b0;
        end else if (tc) begin
          bus.rsp_product <= '0;
          bus.rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign ctr_clear = (state == S_LAUNCH);
  assign ctr_en    = (state == S_WAIT);

  mult_timeout_ctr #(
    .TC_VALUE (TC_LAST)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .tc     (tc)
  );

  // req_ready is gated by rst so it stays low while reset is held.
  assign bus.req_ready = (state == S_IDLE) && rst;
  assign bus.mul_start = (state == S_LAUNCH);
  assign bus.rsp_valid = (state == S_RESP);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mult_host.sv
// Directed testbench for mult_host (TIMEOUT_CYCLES = 15).
// The bench plays both the host and the multiplier.
module tb_mult_host;
  import mult_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   n_chk;
  int   n_pass;
  int   n_start;
  int   start_base;

  mult_host_if mif ();

  mult_host #(
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (mif.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial n_start = 0;
  always @(posedge clk) begin
    if (mif.mul_start) n_start = n_start + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one accepting edge.
  task automatic send_req(input logic [3:0] a, input logic [3:0] b);
    mif.req_valid = 1'b1;
    mif.a_in      = a;
    mif.b_in      = b;
    tick();
    mif.req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(busy),            32'd0);
    chk({tag, "_req_ready"}, 32'(mif.req_ready),   32'd0);
    chk({tag, "_mul_start"}, 32'(mif.mul_start),   32'd0);
    chk({tag, "_rsp_valid"}, 32'(mif.rsp_valid),   32'd0);
    chk({tag, "_rsp_tmo"},   32'(mif.rsp_timeout), 32'd0);
    chk({tag, "_rsp_prod"},  32'(mif.rsp_product), 32'd0);
    chk({tag, "_mul_a"},     32'(mif.mul_a),       32'd0);
    chk({tag, "_mul_b"},     32'(mif.mul_b),       32'd0);
  endtask

  initial begin
    n_chk           = 0;
    n_pass          = 0;
    rst             = 1'b0;
    mif.req_valid   = 1'b0;
    mif.a_in        = '0;
    mif.b_in        = '0;
    mif.mul_done    = 1'b0;
    mif.mul_product = '0;
    mif.rsp_ready   = 1'b0;

    // reset state
    #2;
    chk_reset_outputs("rst0");
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_req_ready", 32'(mif.req_ready), 32'd1);
    chk("rel_busy",      32'(busy),          32'd0);

    // 3 x 5, done two cycles after mul_start
    start_base = n_start;
    send_req(4'd3, 4'd5);
    chk("t1_launch_start", 32'(mif.mul_start), 32'd1);
    chk("t1_launch_rdy",   32'(mif.req_ready), 32'd0);
    chk("t1_launch_busy",  32'(busy),          32'd1);
    chk("t1_mul_a",        32'(mif.mul_a),     32'd3);
    chk("t1_mul_b",        32'(mif.mul_b),     32'd5);
    tick();
    chk("t1_w1_start", 32'(mif.mul_start), 32'd0);
    chk("t1_w1_valid", 32'(mif.rsp_valid), 32'd0);
    tick();
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd15;
    mif.rsp_ready   = 1'b1;
    tick();
    mif.mul_done    = 1'b0;
    chk("t1_rsp_valid", 32'(mif.rsp_valid),   32'd1);
    chk("t1_rsp_prod",  32'(mif.rsp_product), 32'd15);
    chk("t1_rsp_tmo",   32'(mif.rsp_timeout), 32'd0);
    tick();
    mif.rsp_ready = 1'b0;
    chk("t1_idle_valid", 32'(mif.rsp_valid), 32'd0);
    chk("t1_idle_rdy",   32'(mif.req_ready), 32'd1);
    chk("t1_start_cnt",  32'(n_start - start_base), 32'd1);

    // 15 x 15, host stalls the response for 5 cycles
    send_req(4'd15, 4'd15);
    tick();
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd225;
    tick();
    mif.mul_done  = 1'b0;
    mif.req_valid = 1'b1;
    mif.a_in      = 4'd1;
    mif.b_in      = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(mif.rsp_valid),   32'd1);
      chk("t2_hold_prod",  32'(mif.rsp_product), 32'd225);
      chk("t2_hold_rdy",   32'(mif.req_ready),   32'd0);
      chk("t2_hold_mul_a", 32'(mif.mul_a),       32'd15);
      tick();
    end
    mif.req_valid = 1'b0;
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;
    chk("t2_done_valid", 32'(mif.rsp_valid), 32'd0);

    // no mul_done: abort after 15 WAIT cycles
    mif.mul_product = 8'hAA;
    send_req(4'd6, 4'd9);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("t3_wait_valid", 32'(mif.rsp_valid), 32'd0);
      tick();
    end
    chk("t3_rsp_valid", 32'(mif.rsp_valid),   32'd1);
    chk("t3_rsp_tmo",   32'(mif.rsp_timeout), 32'd1);
    chk("t3_rsp_prod",  32'(mif.rsp_product), 32'd0);
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // reset during WAIT, then 2 x 7
    send_req(4'd9, 4'd9);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("t4_rst");
    tick();
    rst = 1'b1;
    #1;
    chk("t4_rel_rdy", 32'(mif.req_ready), 32'd1);
    tick();
    chk("t4_no_rsp", 32'(mif.rsp_valid), 32'd0);
    send_req(4'd2, 4'd7);
    tick();
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd14;
    mif.rsp_ready   = 1'b1;
    tick();
    mif.mul_done = 1'b0;
    chk("t4_rsp_valid", 32'(mif.rsp_valid),   32'd1);
    chk("t4_rsp_prod",  32'(mif.rsp_product), 32'd14);
    chk("t4_rsp_tmo",   32'(mif.rsp_timeout), 32'd0);
    tick();
    mif.rsp_ready = 1'b0;

    // mul_done in IDLE and in LAUNCH is ignored
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'h55;
    tick();
    chk("t5_idle_busy",  32'(busy),          32'd0);
    chk("t5_idle_valid", 32'(mif.rsp_valid), 32'd0);
    send_req(4'd4, 4'd3);
    chk("t5_launch", 32'(mif.mul_start), 32'd1);
    tick();
    mif.mul_done = 1'b0;
    chk("t5_w1_valid", 32'(mif.rsp_valid), 32'd0);
    tick();
    chk("t5_w2_valid", 32'(mif.rsp_valid), 32'd0);
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd12;
    tick();
    mif.mul_done = 1'b0;
    chk("t5_rsp_prod", 32'(mif.rsp_product), 32'd12);
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;

    // done on the first WAIT cycle -> response on the next cycle
    send_req(4'd5, 4'd5);
    tick();
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd25;
    tick();
    mif.mul_done = 1'b0;
    chk("t5b_rsp_valid", 32'(mif.rsp_valid),   32'd1);
    chk("t5b_rsp_prod",  32'(mif.rsp_product), 32'd25);
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;

    // done on the terminal WAIT cycle wins over the timeout
    send_req(4'd7, 4'd8);
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("t6_last_wait", 32'(mif.rsp_valid), 32'd0);
    mif.mul_done    = 1'b1;
    mif.mul_product = 8'd56;
    tick();
    chk("t6_rsp_valid", 32'(mif.rsp_valid),   32'd1);
    chk("t6_rsp_tmo",   32'(mif.rsp_timeout), 32'd0);
    chk("t6_rsp_prod",  32'(mif.rsp_product), 32'd56);
    // mul_done during RESP must not overwrite the result
    mif.mul_product = 8'h99;
    tick();
    mif.mul_done = 1'b0;
    chk("t6_resp_hold", 32'(mif.rsp_product), 32'd56);
    chk("t6_resp_tmo",  32'(mif.rsp_timeout), 32'd0);
    mif.rsp_ready = 1'b1;
    tick();
    mif.rsp_ready = 1'b0;
    chk("t6_idle_valid", 32'(mif.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
